imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 166 ++++++++++++++++
 tb/tb_imm_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes RV immediates and format, buffers them
// in a 2-entry in-order FIFO, and counts illegal encodings delivered.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic            ill;
  } ent_t;

  logic [6:0]         op;
  logic signed [31:0] i32, s32, b32, u32, j32;
  ent_t               dec;

  assign op = in_instr[6:0];

  always_comb begin
    i32 = {{20{in_instr[31]}}, in_instr[31:20]};
    s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    b32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
           in_instr[30:25], in_instr[11:8], 1'b0};
    u32 = {in_instr[31:12], 12'b0};
    j32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
           in_instr[20], in_instr[30:21], 1'b0};
  end

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.ill = 1'b0;
    unique case (op)
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b0001111: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'(i32);
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'(s32);
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'(b32);
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'(u32);
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'(j32);
      end
      7'b0110011: dec.fmt = FMT_NONE;
      7'b1110011: begin
        if (in_instr[14]) begin
          dec.fmt = FMT_Z;
          dec.imm = XLEN'(in_instr[19:15]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'(i32);
        end
      end
      // RV64-only word ops
      7'b0011011: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'(i32);
        end else begin
          dec.ill = 1'b1;
        end
      end
      7'b0111011: dec.ill = (XLEN != 64);
      default:    dec.ill = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) dec.ill = 1'b1;
    if (dec.ill) begin
      dec.imm = '0;
      dec.fmt = FMT_NONE;
    end
  end

  logic [1:0]       count_q, count_d;
  ent_t             head_q, head_d;
  ent_t             tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = ~count_q[1];
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = dec;
          else                 tail_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: head_d = dec;
        default: ;
      endcase
      if (pop && head_q.ill && !(&cnt_q))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_imm     = out_valid ? head_q.imm : '0;
  assign out_fmt     = out_valid ? head_q.fmt : '0;
  assign out_pc      = out_valid ? head_q.pc  : '0;
  assign out_illegal = out_valid && head_q.ill;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: XLEN=32, XLEN=64 and a
// 2-bit counter instance share one stimulus stream.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_ir, a_ov, a_ill;
  logic [31:0] a_imm, a_pc;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;

  logic        b_ir, b_ov, b_ill;
  logic [63:0] b_imm, b_pc;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;

  logic        c_ir, c_ov, c_ill;
  logic [31:0] c_imm, c_pc;
  logic [2:0]  c_fmt;
  logic [1:0]  c_cnt;

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ir),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_pc(a_pc),
    .out_illegal(a_ill), .illegal_cnt(a_cnt)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_ir),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_pc(b_pc),
    .out_illegal(b_ill), .illegal_cnt(b_cnt)
  );

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) uc2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_ir),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(c_ov), .out_ready(out_ready),
    .out_imm(c_imm), .out_fmt(c_fmt), .out_pc(c_pc),
    .out_illegal(c_ill), .illegal_cnt(c_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t cur32, cur64;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt32, m_cnt64, m_cnt2;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt,
                              input logic [63:0] pc, input logic ill);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  // Reference decode built from shifted signed fields
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc,
                                 input bit x64);
    exp_t               e;
    logic signed [31:0] t;
    logic signed [63:0] v;
    e.ill = 1'b0; e.fmt = 3'd0; v = '0; t = '0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        t = $signed(w) >>> 20; v = t; e.fmt = 3'd1;
      end
      7'b0100011: begin
        t = $signed({w[31:25], w[11:7], 20'h0}) >>> 20; v = t; e.fmt = 3'd2;
      end
      7'b1100011: begin
        t = $signed({w[31], w[7], w[30:25], w[11:8], 20'h0}) >>> 19;
        v = t; e.fmt = 3'd3;
      end
      7'b0110111, 7'b0010111: begin
        t = $signed({w[31:12], 12'h0}); v = t; e.fmt = 3'd4;
      end
      7'b1101111: begin
        t = $signed({w[31], w[19:12], w[20], w[30:21], 12'h0}) >>> 11;
        v = t; e.fmt = 3'd5;
      end
      7'b0110011: e.fmt = 3'd0;
      7'b1110011: begin
        if (w[14]) begin
          v = {59'h0, w[19:15]}; e.fmt = 3'd6;
        end else begin
          t = $signed(w) >>> 20; v = t; e.fmt = 3'd1;
        end
      end
      7'b0011011: begin
        if (x64) begin t = $signed(w) >>> 20; v = t; e.fmt = 3'd1; end
        else e.ill = 1'b1;
      end
      7'b0111011: e.ill = !x64;
      default:    e.ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) e.ill = 1'b1;
    if (e.ill) begin v = '0; e.fmt = 3'd0; end
    e.imm = x64 ? v : {32'h0, v[31:0]};
    e.pc  = x64 ? pc : {32'h0, pc[31:0]};
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_k(input logic [31:0] w, input logic [63:0] pc,
                        input exp_t e32, input exp_t e64);
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    cur32 = e32; cur64 = e64;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    send_k(w, pc, model(w, pc, 1'b0), model(w, pc, 1'b1));
  endtask

  // Monitor: checks registered state against the model, then advances it
  always @(negedge clk) begin
    int sz;
    if (rst) begin
      q32.delete(); q64.delete();
      m_cnt32 = 0; m_cnt64 = 0; m_cnt2 = 0;
    end else begin
      sz = q32.size();
      chk("cnt32", 64'(a_cnt), 64'(m_cnt32));
      chk("cnt64", 64'(b_cnt), 64'(m_cnt64));
      chk("cnt2",  64'(c_cnt), 64'(m_cnt2));
      chk("vld32", 64'(a_ov), 64'(sz != 0));
      chk("vld64", 64'(b_ov), 64'(sz != 0));
      chk("rdy32", 64'(a_ir), 64'(sz < 2));
      chk("rdy64", 64'(b_ir), 64'(sz < 2));
      chk("rdyc2", 64'(c_ir), 64'(sz < 2));
      if (sz != 0) begin
        chk("imm32", {32'h0, a_imm}, q32[0].imm);
        chk("fmt32", 64'(a_fmt), 64'(q32[0].fmt));
        chk("pc32",  {32'h0, a_pc}, q32[0].pc);
        chk("ill32", 64'(a_ill), 64'(q32[0].ill));
        chk("imm64", b_imm, q64[0].imm);
        chk("fmt64", 64'(b_fmt), 64'(q64[0].fmt));
        chk("pc64",  b_pc, q64[0].pc);
        chk("ill64", 64'(b_ill), 64'(q64[0].ill));
        chk("immc2", {32'h0, c_imm}, q32[0].imm);
      end
      if (flush) begin
        q32.delete(); q64.delete();
      end else begin
        if (out_ready && sz != 0) begin
          if (q32[0].ill && m_cnt32 < 65535) m_cnt32++;
          if (q32[0].ill && m_cnt2 < 3) m_cnt2++;
          if (q64[0].ill && m_cnt64 < 65535) m_cnt64++;
          void'(q32.pop_front());
          void'(q64.pop_front());
        end
        if (in_valid && sz < 2) begin
          q32.push_back(cur32);
          q64.push_back(cur64);
        end
      end
    end
  end

  logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b1101111, 7'b0110011,
                           7'b1110011, 7'b0011011, 7'b0111011, 7'b1010111};

  initial begin
    logic [31:0] r;
    int          saved;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_vld", 64'(a_ov), 64'd0);
    chk("rst_rdy", 64'(a_ir), 64'd1);
    chk("rst_imm", b_imm, 64'd0);
    chk("rst_fmt", 64'(b_fmt), 64'd0);
    chk("rst_pc",  b_pc, 64'd0);
    chk("rst_ill", 64'(a_ill), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);

    // Basic formats, one per cycle
    out_ready = 1'b1;
    send_k(32'h00A10093, 64'h100, mk(64'd10, 3'd1, 64'h100, 1'b0),
                                  mk(64'd10, 3'd1, 64'h100, 1'b0));
    send_k(32'h00112423, 64'h104, mk(64'd8, 3'd2, 64'h104, 1'b0),
                                  mk(64'd8, 3'd2, 64'h104, 1'b0));
    send_k(32'h00208863, 64'h108, mk(64'd16, 3'd3, 64'h108, 1'b0),
                                  mk(64'd16, 3'd3, 64'h108, 1'b0));
    send_k(32'hABCDE0B7, 64'h10C,
           mk(64'h00000000ABCDE000, 3'd4, 64'h10C, 1'b0),
           mk(64'hFFFFFFFFABCDE000, 3'd4, 64'h10C, 1'b0));
    send_k(32'h010000EF, 64'h110, mk(64'd16, 3'd5, 64'h110, 1'b0),
                                  mk(64'd16, 3'd5, 64'h110, 1'b0));
    cyc();
    send_k(32'h7C0FD073, 64'h200, mk(64'h1F, 3'd6, 64'h200, 1'b0),
                                  mk(64'h1F, 3'd6, 64'h200, 1'b0));
    send_k(32'h00000010, 64'h204, mk(64'd0, 3'd0, 64'h204, 1'b1),
                                  mk(64'd0, 3'd0, 64'h204, 1'b1));
    repeat (2) cyc();
    chk("ill_cnt1", 64'(a_cnt), 64'd1);
    send_k(32'hFFF1009B, 64'h208, mk(64'd0, 3'd0, 64'h208, 1'b1),
           mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h208, 1'b0));
    repeat (2) cyc();

    // Random mix with random backpressure
    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      out_ready = r[0];
      if (r[1]) begin
        r = $urandom();
        send({r[31:7], ops[r[3:0] % 12]}, 64'($urandom()) << 2);
      end else begin
        cyc();
      end
    end
    out_ready = 1'b1;
    repeat (3) cyc();

    // Backpressure: third offer is refused, head holds
    out_ready = 1'b0;
    send(32'h00100093, 64'h300);
    send(32'h00200093, 64'h304);
    send(32'h00300093, 64'h308);
    chk("bp_rdy0", 64'(a_ir), 64'd0);
    chk("bp_head", {32'h0, a_imm}, 64'd1);
    cyc();
    chk("bp_hold", {32'h0, a_imm}, 64'd1);
    out_ready = 1'b1;
    chk("bp_rdyp", 64'(a_ir), 64'd0);
    cyc();
    chk("bp_rdy1", 64'(a_ir), 64'd1);
    chk("bp_2nd",  {32'h0, a_imm}, 64'd2);
    repeat (2) cyc();

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      r = $urandom();
      send({r[31:2], 2'b00}, 64'h400 + 64'(i * 4));
    end
    repeat (2) cyc();
    chk("cnt2_sat", 64'(c_cnt), 64'd3);

    // Flush of a full FIFO with a popping illegal head and a live input
    out_ready = 1'b0;
    send(32'h00000010, 64'h500);
    send(32'h00000020, 64'h504);
    saved = m_cnt32;
    out_ready = 1'b1; flush = 1'b1;
    send(32'h00000030, 64'h508);
    flush = 1'b0;
    chk("fl_vld", 64'(a_ov), 64'd0);
    chk("fl_rdy", 64'(a_ir), 64'd1);
    chk("fl_cnt", 64'(a_cnt), 64'(saved));
    cyc();

    // Reset during streaming
    out_ready = 1'b0;
    send(32'h00A10093, 64'h600);
    send(32'hABCDE0B7, 64'h604);
    rst = 1'b1;
    send(32'h010000EF, 64'h608);
    rst = 1'b0;
    chk("rs_vld", 64'(b_ov), 64'd0);
    chk("rs_rdy", 64'(b_ir), 64'd1);
    chk("rs_imm", b_imm, 64'd0);
    chk("rs_fmt", 64'(b_fmt), 64'd0);
    chk("rs_pc",  b_pc, 64'd0);
    chk("rs_ill", 64'(a_ill), 64'd0);
    chk("rs_cnt", 64'(a_cnt), 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
